// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: jump-select encodings and datapath widths.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int JIDX_W = 26;

    typedef logic [1:0] jr_sel_t;

    localparam jr_sel_t JR_REG  = 2'd0;
    localparam jr_sel_t JR_ABS  = 2'd1;
    localparam jr_sel_t JR_NONE = 2'd2;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data RAM: byte-enable synchronous write, asynchronous read.
module data_memory #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              Clk,
    input  logic              WE,
    input  logic [3:0]        BE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData
);

    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge Clk) begin
        if (WE) begin
            for (int i = 0; i < 4; i++) begin
                if (BE[i]) r_mem[Addr][8*i +: 8] <= WData[8*i +: 8];
            end
        end
    end

    assign RData = r_mem[Addr];

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access with sub-word loads/stores,
// branch/jump resolution and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Mbranch,
    input  logic              Mmemread,
    input  logic              Mmemwrite,
    input  logic              Mmemtoreg,
    input  logic              Mregwrite,
    input  logic              Mcntrljalr,
    input  logic              Mcntrljald,
    input  logic              Mlh,
    input  logic              Mlb,
    input  logic              Msh,
    input  logic              Msb,
    input  jr_sel_t           Mcntrljr,
    input  logic [JIDX_W-1:0] M250Inst,
    input  logic [DATA_W-1:0] MRD1,
    input  logic [DATA_W-1:0] MPCAddResult,
    input  logic [DATA_W-1:0] MAddResult,
    input  logic              MAluZero,
    input  logic [DATA_W-1:0] MAluResult,
    input  logic [DATA_W-1:0] MRD2,
    input  logic [REG_W-1:0]  MRegDst,
    output logic              PCSrc,
    output logic [DATA_W-1:0] PCTarget,
    output logic              Flush,
    output logic              Wregwrite,
    output logic              Wmemtoreg,
    output logic              Wlink,
    output logic [DATA_W-1:0] WReadData,
    output logic [DATA_W-1:0] WAluResult,
    output logic [DATA_W-1:0] WPCAddResult,
    output logic [REG_W-1:0]  WRegDst
);

    logic              w_we;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_load;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_pcsrc;
    logic              w_unused_addr;

    // Address bits above the word index are ignored, so accesses wrap.
    assign w_unused_addr = ^MAluResult[DATA_W-1:ADDR_W+2];

    assign w_we = Mmemwrite & ~Rst;

    always_comb begin
        w_be    = 4'hF;
        w_wdata = MRD2;
        if (Msb) begin
            w_be    = 4'b0001 << MAluResult[1:0];
            w_wdata = {4{MRD2[7:0]}};
        end else if (Msh) begin
            w_be    = MAluResult[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{MRD2[15:0]}};
        end
    end

    data_memory #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_dmem (
        .Clk   (Clk),
        .WE    (w_we),
        .BE    (w_be),
        .Addr  (MAluResult[ADDR_W+1:2]),
        .WData (w_wdata),
        .RData (w_rdata)
    );

    always_comb begin
        w_byte = w_rdata[{MAluResult[1:0], 3'b000} +: 8];
        w_half = MAluResult[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_load = '0;
        if (Mmemread) begin
            if (Mlb)      w_load = {{24{w_byte[7]}}, w_byte};
            else if (Mlh) w_load = {{16{w_half[15]}}, w_half};
            else          w_load = w_rdata;
        end
    end

    always_comb begin
        w_pcsrc  = 1'b0;
        PCTarget = MPCAddResult;
        case (Mcntrljr)
            JR_REG: begin
                w_pcsrc  = 1'b1;
                PCTarget = MRD1;
            end
            JR_ABS: begin
                w_pcsrc  = 1'b1;
                PCTarget = {MPCAddResult[31:28], M250Inst, 2'b00};
            end
            default: begin
                if (Mbranch & MAluZero) begin
                    w_pcsrc  = 1'b1;
                    PCTarget = MAddResult;
                end
            end
        endcase
    end

    assign PCSrc = w_pcsrc & ~Rst;
    assign Flush = PCSrc;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Wregwrite    <= 1'b0;
            Wmemtoreg    <= 1'b0;
            Wlink        <= 1'b0;
            WReadData    <= '0;
            WAluResult   <= '0;
            WPCAddResult <= '0;
            WRegDst      <= '0;
        end else begin
            Wregwrite    <= Mregwrite;
            Wmemtoreg    <= Mmemtoreg;
            Wlink        <= Mcntrljalr | Mcntrljald;
            WReadData    <= w_load;
            WAluResult   <= MAluResult;
            WPCAddResult <= MPCAddResult;
            WRegDst      <= MRegDst;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected MEM/WB contents are queued when
// an operation is driven and compared one edge later; redirects checked in-cycle.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Mbranch, Mmemread, Mmemwrite, Mmemtoreg, Mregwrite;
    logic        Mcntrljalr, Mcntrljald, Mlh, Mlb, Msh, Msb;
    logic [1:0]  Mcntrljr;
    logic [25:0] M250Inst;
    logic [31:0] MRD1, MPCAddResult, MAddResult, MAluResult, MRD2;
    logic        MAluZero;
    logic [4:0]  MRegDst;
    logic        PCSrc, Flush, Wregwrite, Wmemtoreg, Wlink;
    logic [31:0] PCTarget, WReadData, WAluResult, WPCAddResult;
    logic [4:0]  WRegDst;

    mem_stage #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
        .Clk(Clk), .Rst(Rst),
        .Mbranch(Mbranch), .Mmemread(Mmemread), .Mmemwrite(Mmemwrite),
        .Mmemtoreg(Mmemtoreg), .Mregwrite(Mregwrite),
        .Mcntrljalr(Mcntrljalr), .Mcntrljald(Mcntrljald),
        .Mlh(Mlh), .Mlb(Mlb), .Msh(Msh), .Msb(Msb),
        .Mcntrljr(Mcntrljr), .M250Inst(M250Inst), .MRD1(MRD1),
        .MPCAddResult(MPCAddResult), .MAddResult(MAddResult),
        .MAluZero(MAluZero), .MAluResult(MAluResult), .MRD2(MRD2),
        .MRegDst(MRegDst),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .Flush(Flush),
        .Wregwrite(Wregwrite), .Wmemtoreg(Wmemtoreg), .Wlink(Wlink),
        .WReadData(WReadData), .WAluResult(WAluResult),
        .WPCAddResult(WPCAddResult), .WRegDst(WRegDst)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd, wr, lb, lh, sb, sh;
        logic [31:0] addr, wdata, exp_rd;
        string       name;
    } op_t;

    typedef struct {
        logic [31:0] rd, alu, pc;
        logic [4:0]  dst;
        logic        link, regw, mtr;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic op_t mk(input string name, input logic rd, wr, lb, lh, sb, sh,
                               input logic [31:0] addr, wdata, exp_rd);
        op_t o;
        o.name = name; o.rd = rd; o.wr = wr; o.lb = lb; o.lh = lh; o.sb = sb; o.sh = sh;
        o.addr = addr; o.wdata = wdata; o.exp_rd = exp_rd;
        return o;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Mbranch = 0; Mmemread = 0; Mmemwrite = 0; Mmemtoreg = 0; Mregwrite = 0;
        Mcntrljalr = 0; Mcntrljald = 0; Mlh = 0; Mlb = 0; Msh = 0; Msb = 0;
        Mcntrljr = 2'd2; M250Inst = '0; MRD1 = '0; MPCAddResult = 32'h0000_1000;
        MAddResult = '0; MAluZero = 0; MAluResult = '0; MRD2 = '0; MRegDst = '0;
    endtask

    // Drives one memory op and queues the MEM/WB contents it must produce.
    task automatic issue(input op_t o);
        exp_t e;
        idle();
        Mmemread = o.rd; Mmemwrite = o.wr; Mlb = o.lb; Mlh = o.lh; Msb = o.sb; Msh = o.sh;
        MAluResult = o.addr; MRD2 = o.wdata;
        Mregwrite = o.rd; Mmemtoreg = o.rd; MRegDst = o.rd ? 5'd9 : 5'd0;
        MPCAddResult = 32'h0000_2000 + o.addr;
        e.rd = o.exp_rd; e.alu = o.addr; e.pc = 32'h0000_2000 + o.addr;
        e.dst = o.rd ? 5'd9 : 5'd0; e.link = 1'b0; e.regw = o.rd; e.mtr = o.rd;
        e.name = o.name;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        idle();
        Rst = 1'b1;
        Mcntrljr = 2'd0; MRD1 = 32'h0000_0444;
        Mregwrite = 1; Mmemtoreg = 1; Mcntrljald = 1; MAluResult = 32'h55; MRegDst = 5'd3;
        tick(); tick();
        total++;
        if ({Wregwrite, Wmemtoreg, Wlink, WReadData, WAluResult, WPCAddResult, WRegDst} !== '0) begin
            bad++;
            $display("FAIL reset_w: regw=%b mtr=%b link=%b rd=%h alu=%h pc=%h dst=%0d required all 0",
                     Wregwrite, Wmemtoreg, Wlink, WReadData, WAluResult, WPCAddResult, WRegDst);
        end
        total++;
        if (PCSrc !== 1'b0 || Flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_pcsrc: pcsrc=%b flush=%b required 0 0", PCSrc, Flush);
        end
        Rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_table(input string tname, input op_t ops[$]);
        exp_t e;
        foreach (ops[i]) begin
            issue(ops[i]);
            tick();
            e = sb_q.pop_front();
            total++;
            if (WReadData !== e.rd || WAluResult !== e.alu || WPCAddResult !== e.pc ||
                WRegDst !== e.dst || Wlink !== e.link || Wregwrite !== e.regw || Wmemtoreg !== e.mtr) begin
                bad++;
                $display("FAIL %s/%s: rd=%h alu=%h pc=%h dst=%0d link=%b regw=%b mtr=%b required rd=%h alu=%h pc=%h dst=%0d link=%b regw=%b mtr=%b",
                         tname, e.name, WReadData, WAluResult, WPCAddResult, WRegDst, Wlink, Wregwrite, Wmemtoreg,
                         e.rd, e.alu, e.pc, e.dst, e.link, e.regw, e.mtr);
            end
        end
    endtask

    task automatic test_word();
        op_t t[$];
        t.push_back(mk("sw_10",   0, 1, 0, 0, 0, 0, 32'h10, 32'hDEAD_BEEF, 32'h0));
        t.push_back(mk("lw_10",   1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF));
        t.push_back(mk("bubble",  0, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0));
        t.push_back(mk("sw_wrap", 0, 1, 0, 0, 0, 0, 32'h0000_1030, 32'hCAFE_0001, 32'h0));
        t.push_back(mk("lw_30",   1, 0, 0, 0, 0, 0, 32'h30, 32'h0, 32'hCAFE_0001));
        test_table("word", t);
    endtask

    task automatic test_byte();
        op_t t[$];
        t.push_back(mk("sb_13",    0, 1, 0, 0, 1, 0, 32'h13, 32'hAAAA_AA80, 32'h0));
        t.push_back(mk("lb_13",    1, 0, 1, 0, 0, 0, 32'h13, 32'h0, 32'hFFFF_FF80));
        t.push_back(mk("lw_10",    1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h80AD_BEEF));
        t.push_back(mk("lb_11",    1, 0, 1, 0, 0, 0, 32'h11, 32'h0, 32'hFFFF_FFBE));
        t.push_back(mk("sb_pri",   0, 1, 0, 0, 1, 1, 32'h11, 32'h0000_5A7C, 32'h0));
        t.push_back(mk("lw_pri",   1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h80AD_7CEF));
        t.push_back(mk("lb_lh_pri",1, 0, 1, 1, 0, 0, 32'h12, 32'h0, 32'hFFFF_FFAD));
        t.push_back(mk("lb_pos",   1, 0, 1, 0, 0, 0, 32'h11, 32'h0, 32'h0000_007C));
        test_table("byte", t);
    endtask

    task automatic test_half();
        op_t t[$];
        t.push_back(mk("sw_20",  0, 1, 0, 0, 0, 0, 32'h20, 32'h8765_F00D, 32'h0));
        t.push_back(mk("sh_22",  0, 1, 0, 0, 0, 1, 32'h22, 32'hFFFF_1234, 32'h0));
        t.push_back(mk("lh_22",  1, 0, 0, 1, 0, 0, 32'h22, 32'h0, 32'h0000_1234));
        t.push_back(mk("lh_21",  1, 0, 0, 1, 0, 0, 32'h21, 32'h0, 32'hFFFF_F00D));
        t.push_back(mk("lw_20",  1, 0, 0, 0, 0, 0, 32'h20, 32'h0, 32'h1234_F00D));
        t.push_back(mk("sh_21",  0, 1, 0, 0, 0, 1, 32'h21, 32'h0000_8001, 32'h0));
        t.push_back(mk("lw_20b", 1, 0, 0, 0, 0, 0, 32'h20, 32'h0, 32'h1234_8001));
        t.push_back(mk("noread", 0, 0, 0, 1, 0, 0, 32'h20, 32'h0, 32'h0));
        test_table("half", t);
    endtask

    task automatic test_rw_same();
        op_t t[$];
        t.push_back(mk("rw_10", 1, 1, 0, 0, 0, 0, 32'h10, 32'h0BAD_F00D, 32'h80AD_7CEF));
        t.push_back(mk("lw_10", 1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0BAD_F00D));
        test_table("rw_same", t);
    endtask

    task automatic test_branch();
        idle();
        Mbranch = 1; MAluZero = 1; MAddResult = 32'h40; MPCAddResult = 32'h0000_0104;
        #1;
        total++;
        if (PCSrc !== 1'b1 || Flush !== 1'b1 || PCTarget !== 32'h40) begin
            bad++;
            $display("FAIL br_taken: pcsrc=%b flush=%b tgt=%h required 1 1 00000040", PCSrc, Flush, PCTarget);
        end
        MAluZero = 0;
        #1;
        total++;
        if (PCSrc !== 1'b0 || Flush !== 1'b0 || PCTarget !== 32'h0000_0104) begin
            bad++;
            $display("FAIL br_not_taken: pcsrc=%b flush=%b tgt=%h required 0 0 00000104", PCSrc, Flush, PCTarget);
        end
        Mbranch = 0; MAluZero = 1;
        #1;
        total++;
        if (PCSrc !== 1'b0) begin
            bad++;
            $display("FAIL br_nobranch: pcsrc=%b required 0", PCSrc);
        end
        tick();
    endtask

    task automatic test_jump();
        exp_t e;
        idle();
        Mcntrljr = 2'd1; MPCAddResult = 32'h8000_0004; M250Inst = 26'h10;
        Mbranch = 1; MAluZero = 1; MAddResult = 32'h40;
        #1;
        total++;
        if (PCSrc !== 1'b1 || Flush !== 1'b1 || PCTarget !== 32'h8000_0040) begin
            bad++;
            $display("FAIL j_abs: pcsrc=%b flush=%b tgt=%h required 1 1 80000040", PCSrc, Flush, PCTarget);
        end
        tick();
        idle();
        Mcntrljr = 2'd0; Mcntrljalr = 1; Mregwrite = 1; MRD1 = 32'h100;
        MPCAddResult = 32'h0000_0208; MRegDst = 5'd1; MAluResult = 32'h0000_0300;
        Mbranch = 1; MAluZero = 1; MAddResult = 32'h40;
        #1;
        total++;
        if (PCSrc !== 1'b1 || Flush !== 1'b1 || PCTarget !== 32'h100) begin
            bad++;
            $display("FAIL jalr_tgt: pcsrc=%b flush=%b tgt=%h required 1 1 00000100", PCSrc, Flush, PCTarget);
        end
        e.rd = '0; e.alu = 32'h300; e.pc = 32'h208; e.dst = 5'd1;
        e.link = 1; e.regw = 1; e.mtr = 0; e.name = "jalr_wb";
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        total++;
        if (Wlink !== e.link || Wregwrite !== e.regw || WPCAddResult !== e.pc || WRegDst !== e.dst) begin
            bad++;
            $display("FAIL %s: link=%b regw=%b pc=%h dst=%0d required link=%b regw=%b pc=%h dst=%0d",
                     e.name, Wlink, Wregwrite, WPCAddResult, WRegDst, e.link, e.regw, e.pc, e.dst);
        end
        idle();
        Mcntrljr = 2'd3; MPCAddResult = 32'h0000_0ABC; MRD1 = 32'h100;
        #1;
        total++;
        if (PCSrc !== 1'b0 || PCTarget !== 32'h0000_0ABC) begin
            bad++;
            $display("FAIL jr_reserved: pcsrc=%b tgt=%h required 0 00000abc", PCSrc, PCTarget);
        end
        Mcntrljr = 2'd1; Mcntrljald = 1; MPCAddResult = 32'h1234_5678;
        e.rd = '0; e.alu = '0; e.pc = 32'h1234_5678; e.dst = 5'd0;
        e.link = 1; e.regw = 0; e.mtr = 0; e.name = "jal_wb";
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        total++;
        if (Wlink !== e.link || Wregwrite !== e.regw || WPCAddResult !== e.pc) begin
            bad++;
            $display("FAIL %s: link=%b regw=%b pc=%h required link=%b regw=%b pc=%h",
                     e.name, Wlink, Wregwrite, WPCAddResult, e.link, e.regw, e.pc);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_store();
        op_t t[$];
        op_t l[$];
        t.push_back(mk("sw_0", 0, 1, 0, 0, 0, 0, 32'h0, 32'h1122_3344, 32'h0));
        test_table("rst_store_pre", t);
        issue(mk("sw_0_rst", 0, 1, 0, 0, 0, 0, 32'h0, 32'h0000_0055, 32'h0));
        void'(sb_q.pop_back());
        Rst = 1'b1;
        tick();
        total++;
        if ({Wregwrite, Wmemtoreg, Wlink, WReadData, WAluResult, WPCAddResult, WRegDst} !== '0) begin
            bad++;
            $display("FAIL rst_store_w: regw=%b mtr=%b link=%b rd=%h alu=%h pc=%h dst=%0d required all 0",
                     Wregwrite, Wmemtoreg, Wlink, WReadData, WAluResult, WPCAddResult, WRegDst);
        end
        Rst = 1'b0;
        l.push_back(mk("lw_0", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h1122_3344));
        test_table("rst_store", l);
    endtask

    // Random sub-word traffic in 0x200..0x2FF against a byte-array model;
    // random upper address bits exercise the wrap-around.
    task automatic test_back_to_back();
        logic [7:0]  mdl [256];
        op_t         t[$];
        logic [31:0] w, a, exp_v;
        int          o, kind;
        for (int i = 0; i < 64; i++) begin
            w = $urandom();
            for (int b = 0; b < 4; b++) mdl[4*i+b] = w[8*b +: 8];
            t.push_back(mk("init", 0, 1, 0, 0, 0, 0, 32'h200 + 4*i, w, 32'h0));
        end
        for (int n = 0; n < 160; n++) begin
            o = $urandom_range(0, 255);
            a = ($urandom() & 32'hFFFF_F000) | (32'h200 + o);
            w = $urandom();
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    t.push_back(mk("sw", 0, 1, 0, 0, 0, 0, a, w, 32'h0));
                    for (int b = 0; b < 4; b++) mdl[(o & 252) + b] = w[8*b +: 8];
                end
                1: begin
                    t.push_back(mk("sh", 0, 1, 0, 0, 0, 1, a, w, 32'h0));
                    mdl[(o & 252) + (o & 2)]     = w[7:0];
                    mdl[(o & 252) + (o & 2) + 1] = w[15:8];
                end
                2: begin
                    t.push_back(mk("sb", 0, 1, 0, 0, 1, 0, a, w, 32'h0));
                    mdl[o] = w[7:0];
                end
                3: begin
                    exp_v = {mdl[(o & 252) + 3], mdl[(o & 252) + 2], mdl[(o & 252) + 1], mdl[o & 252]};
                    t.push_back(mk("lw", 1, 0, 0, 0, 0, 0, a, 32'h0, exp_v));
                end
                4: begin
                    exp_v = {{16{mdl[(o & 252) + (o & 2) + 1][7]}},
                             mdl[(o & 252) + (o & 2) + 1], mdl[(o & 252) + (o & 2)]};
                    t.push_back(mk("lh", 1, 0, 0, 1, 0, 0, a, 32'h0, exp_v));
                end
                default: begin
                    exp_v = {{24{mdl[o][7]}}, mdl[o]};
                    t.push_back(mk("lb", 1, 0, 1, 0, 0, 0, a, 32'h0, exp_v));
                end
            endcase
        end
        test_table("b2b", t);
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_rw_same();
        test_branch();
        test_jump();
        test_reset_store();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
